// File: rtl/lcell_cfg_pkg.sv
// Shared types, constants and CRC helper for the logic-cell config loader.
// LCELL_CFG_CRC_EN enables the CRC-16 trailer check in the loader.
package lcell_cfg_pkg;

  localparam int LUT_W   = 16;
  localparam int FRAME_W = LUT_W + 1;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CRC,
    COMMIT
  } cfg_state_e;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        din
  );
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/lcell_cfg_loader_crc16.sv
// Serial CRC-16-CCITT register: seed, enable, one bit per enabled cycle.
// Only instantiated when LCELL_CFG_CRC_EN is defined.
module lcell_cfg_crc16
  import lcell_cfg_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || seed) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/lcell_cfg_loader.sv
// Serial config loader: shadow frames per cell, atomic commit to live config.
// Define LCELL_CFG_CRC_EN to add the CRC-16 trailer check and CFG_ERR.
module lcell_cfg_loader
  import lcell_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 4,
`ifdef LCELL_CFG_CRC_EN
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
`endif
  parameter int LUT_W = 16
) (
  input  logic                       QCK,
  input  logic                       QRT,
  input  logic                       CFG_START,
  input  logic                       CFG_DI,
  input  logic                       CFG_DV,
  output logic                       CFG_RDY,
  output logic                       CFG_BUSY,
  output logic                       CFG_DONE,
  output logic                       CFG_ERR,
  output logic [NUM_CELLS*LUT_W-1:0] CELL_BITS,
  output logic [NUM_CELLS-1:0]       CELL_CDS
);

  localparam int FW = LUT_W + 1;
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;
  localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);
  localparam logic [BW-1:0] BIT_CDS   = BW'(LUT_W);
  localparam logic [CW-1:0] CELL_LAST = CW'(NUM_CELLS - 1);

  cfg_state_e state_q, state_d;

  logic [BW-1:0]              bit_q;
  logic [CW-1:0]              cell_q;
  logic [NUM_CELLS*LUT_W-1:0] sh_bits;
  logic [NUM_CELLS-1:0]       sh_cds;
  logic                       done_q;
  logic                       acc;
  logic                       load_acc;
  logic                       last_data;
  logic                       crc_fail;

  assign CFG_RDY   = (state_q == LOAD) || (state_q == CRC);
  assign CFG_BUSY  = (state_q != IDLE);
  assign CFG_DONE  = done_q;
  assign acc       = CFG_DV & CFG_RDY & ~CFG_START;
  assign load_acc  = acc && (state_q == LOAD);
  assign last_data = load_acc && (bit_q == BIT_LAST)
                     && (cell_q == CELL_LAST);

`ifdef LCELL_CFG_CRC_EN
  logic [15:0] crc;
  logic [3:0]  crc_cnt_q;
  logic        crc_bad_q;
  logic        crc_bit_bad;
  logic        crc_end;
  logic        crc_pass;
  logic        err_q;

  lcell_cfg_crc16 #(
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk  (QCK),
    .rst  (QRT),
    .seed (CFG_START),
    .en   (load_acc),
    .din  (CFG_DI),
    .crc  (crc)
  );

  // Trailer arrives MSB first; crc is frozen once LOAD ends.
  assign crc_bit_bad = CFG_DI != crc[4'd15 - crc_cnt_q];
  assign crc_end     = acc && (state_q == CRC)
                       && (crc_cnt_q == 4'd15);
  assign crc_pass    = crc_end && !crc_bad_q && !crc_bit_bad;
  assign crc_fail    = crc_end && (crc_bad_q || crc_bit_bad);
  assign CFG_ERR     = err_q;

  always_ff @(posedge QCK) begin
    if (QRT || CFG_START) begin
      crc_cnt_q <= '0;
      crc_bad_q <= 1'b0;
    end else if (acc && (state_q == CRC)) begin
      crc_cnt_q <= crc_cnt_q + 4'd1;
      crc_bad_q <= crc_bad_q | crc_bit_bad;
    end
  end

  always_ff @(posedge QCK) begin
    if (QRT || CFG_START) begin
      err_q <= 1'b0;
    end else if (crc_fail) begin
      err_q <= 1'b1;
    end
  end
`else
  assign crc_fail = 1'b0;
  assign CFG_ERR  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (CFG_START) state_d = LOAD;
      end
      LOAD: begin
        if (CFG_START) begin
          state_d = LOAD;
        end else if (last_data) begin
`ifdef LCELL_CFG_CRC_EN
          state_d = CRC;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef LCELL_CFG_CRC_EN
      CRC: begin
        if (CFG_START)     state_d = LOAD;
        else if (crc_pass) state_d = COMMIT;
        else if (crc_fail) state_d = IDLE;
      end
`endif
      COMMIT: begin
        state_d = CFG_START ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      cell_q    <= '0;
      sh_bits   <= '0;
      sh_cds    <= '0;
      CELL_BITS <= '0;
      CELL_CDS  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        CELL_BITS <= sh_bits;
        CELL_CDS  <= sh_cds;
      end
      if (CFG_START) begin
        bit_q  <= '0;
        cell_q <= '0;
      end else if (load_acc) begin
        for (int k = 0; k < NUM_CELLS; k++) begin
          for (int b = 0; b < LUT_W; b++) begin
            if (cell_q == CW'(k) && bit_q == BW'(b))
              sh_bits[k*LUT_W+b] <= CFG_DI;
          end
          if (cell_q == CW'(k) && bit_q == BIT_CDS)
            sh_cds[k] <= CFG_DI;
        end
        if (bit_q == BIT_LAST) begin
          bit_q <= '0;
          if (cell_q != CELL_LAST) cell_q <= cell_q + 1'b1;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end
      if (crc_fail) begin
        sh_bits <= '0;
        sh_cds  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcell_cfg_loader.sv
// Randomized bench for lcell_cfg_loader against an image-level model.
// Honours LCELL_CFG_CRC_EN when the design is built with it.
`timescale 1ns/1ps
module tb_lcell_cfg_loader;

  localparam int N = 4;
  localparam int L = 16;
`ifdef LCELL_CFG_CRC_EN
  localparam int CB = 16;
`else
  localparam int CB = 0;
`endif
  localparam int TOTAL = N * (L + 1) + CB;

  logic QCK = 1'b0;
  logic QRT, CFG_START, CFG_DI, CFG_DV;
  logic CFG_RDY, CFG_BUSY, CFG_DONE, CFG_ERR;
  logic [N*L-1:0] CELL_BITS;
  logic [N-1:0]   CELL_CDS;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] live_bits;
  logic [3:0]  live_cds;

  always #5 QCK = ~QCK;

  lcell_cfg_loader dut (
    .QCK       (QCK),
    .QRT       (QRT),
    .CFG_START (CFG_START),
    .CFG_DI    (CFG_DI),
    .CFG_DV    (CFG_DV),
    .CFG_RDY   (CFG_RDY),
    .CFG_BUSY  (CFG_BUSY),
    .CFG_DONE  (CFG_DONE),
    .CFG_ERR   (CFG_ERR),
    .CELL_BITS (CELL_BITS),
    .CELL_CDS  (CELL_CDS)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_crc(input bit q[$]);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      fb = c[15] ^ q[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // mode: 0 = DV always, 1 = DV toggling, 2 = random DV
  task automatic run_load(input logic [63:0] bits, input logic [3:0] cds,
                          input int mode, input int limit,
                          input bit bad, input string tag);
    bit          q[$];
    logic [15:0] c;
    int          n, idx, cyc;
    bit          dv, stable;
    for (int k = 0; k < N; k++) begin
      for (int b = 0; b < L; b++) q.push_back(bits[k*L+b]);
      q.push_back(cds[k]);
    end
    if (CB > 0) begin
      c = ref_crc(q);
      for (int i = 15; i >= 0; i--) q.push_back(c[i]);
      if (bad) q[q.size()-1] = ~q[q.size()-1];
    end
    n = (limit < 0) ? TOTAL : limit;

    @(negedge QCK);
    CFG_START = 1'b1;
    CFG_DV    = 1'($urandom_range(0, 1));
    CFG_DI    = 1'($urandom_range(0, 1));
    @(negedge QCK);
    CFG_START = 1'b0;
    chk({tag, "_rdy"}, CFG_RDY, 1'b1);
    chk({tag, "_err_clr"}, CFG_ERR, 1'b0);

    idx = 0;
    cyc = 0;
    stable = 1'b1;
    while (idx < n && cyc < 2000) begin
      if (CELL_BITS !== live_bits || CELL_CDS !== live_cds
          || CFG_DONE !== 1'b0)
        stable = 1'b0;
      case (mode)
        0:       dv = 1'b1;
        1:       dv = (cyc % 2) == 0;
        default: dv = $urandom_range(0, 3) != 0;
      endcase
      CFG_DI = q[idx];
      CFG_DV = dv;
      if (dv && CFG_RDY) idx++;
      cyc++;
      @(negedge QCK);
    end
    CFG_DV = 1'b0;
    chk({tag, "_fed"}, 64'(idx), 64'(n));
    chk({tag, "_hold"}, stable, 1'b1);
    if (limit >= 0) return;

    if (bad && CB > 0) begin
      chk({tag, "_err"}, CFG_ERR, 1'b1);
      chk({tag, "_busy"}, CFG_BUSY, 1'b0);
      @(negedge QCK);
      chk({tag, "_nodone"}, CFG_DONE, 1'b0);
      chk({tag, "_keep"}, CELL_BITS, live_bits);
      chk({tag, "_keepcds"}, CELL_CDS, live_cds);
    end else begin
      chk({tag, "_old"}, CELL_BITS, live_bits);
      chk({tag, "_pre"}, CFG_DONE, 1'b0);
      @(negedge QCK);
      chk({tag, "_bits"}, CELL_BITS, bits);
      chk({tag, "_cds"}, CELL_CDS, cds);
      chk({tag, "_done"}, CFG_DONE, 1'b1);
      live_bits = bits;
      live_cds  = cds;
      @(negedge QCK);
      chk({tag, "_dfall"}, CFG_DONE, 1'b0);
      chk({tag, "_idle"}, CFG_BUSY, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] img;
    logic [63:0] rb;
    QRT = 1'b1;
    CFG_START = 1'b0;
    CFG_DI = 1'b0;
    CFG_DV = 1'b0;
    live_bits = '0;
    live_cds  = '0;
    repeat (2) @(negedge QCK);
    chk("rst_bits", CELL_BITS, 64'h0);
    chk("rst_cds", CELL_CDS, 4'h0);
    chk("rst_rdy", CFG_RDY, 1'b0);
    chk("rst_busy", CFG_BUSY, 1'b0);
    chk("rst_done", CFG_DONE, 1'b0);
    chk("rst_err", CFG_ERR, 1'b0);
    QRT = 1'b0;

    img = 64'h8000_FFFF_0001_A5A5;
    run_load(img, 4'b0101, 0, -1, 1'b0, "t2");

    rb = {$urandom, $urandom};
    run_load(rb, 4'($urandom), 2, -1, 1'b0, "pre3");
    run_load(img, 4'b0101, 1, -1, 1'b0, "t3");

    run_load(rb, 4'($urandom), 0, 30, 1'b0, "t4a");
    run_load(64'h0, 4'hF, 0, -1, 1'b0, "t4");

    run_load({$urandom, $urandom}, 4'($urandom), 2, 40, 1'b0, "t5a");
    @(negedge QCK);
    QRT = 1'b1;
    @(negedge QCK);
    QRT = 1'b0;
    live_bits = '0;
    live_cds  = '0;
    chk("t5_bits", CELL_BITS, 64'h0);
    chk("t5_cds", CELL_CDS, 4'h0);
    chk("t5_busy", CFG_BUSY, 1'b0);
    chk("t5_rdy", CFG_RDY, 1'b0);
    run_load({$urandom, $urandom}, 4'($urandom), 2, -1, 1'b0, "t5");

`ifdef LCELL_CFG_CRC_EN
    run_load(img, 4'b0101, 0, -1, 1'b0, "t6ok");
    run_load(64'h1234_5678_9ABC_DEF0, 4'b1010, 2, -1, 1'b1, "t6bad");
    run_load(img, 4'b0011, 0, -1, 1'b0, "t6next");
`endif

    for (int r = 0; r < 5; r++)
      run_load({$urandom, $urandom}, 4'($urandom), 2, -1, 1'b0, "rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
